ladybird_uart: RTL

//  Memory-mapped 8N1 UART bus secondary. Sits directly downstream of the crossbar on the UART peripheral port (addr[31:28]==4'hF).

---
 rtl/ladybird_uart_pkg.sv | 20 ++
 rtl/ladybird_fifo.sv | 54 +++++
 rtl/ladybird_uart.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ladybird_uart_pkg.sv
// Shared constants and types for the ladybird UART slice.
// Register offsets, STATUS bit positions and the serial FSM state type.
package ladybird_config;

    localparam logic [3:0] UART_DATA_OFFSET   = 4'h0;
    localparam logic [3:0] UART_STATUS_OFFSET = 4'h4;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_RX_NONEMPTY = 1;
    localparam int ST_TX_BUSY     = 2;
    localparam int ST_OVERRUN     = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/ladybird_fifo.sv
// Small synchronous FIFO with extra-bit pointers for full/empty.
// A pop on empty is ignored; push on full is ignored unless a pop frees the slot.
module ladybird_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             anrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW])
                   && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~w_full | w_pop);

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    // Pointer update; reset discards everything held.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage array, written on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/ladybird_uart.sv
// Memory-mapped 8N1 UART secondary: DATA/STATUS registers, TX/RX FIFOs.
// Optional irq output when LADYBIRD_UART_IRQ_EN is defined.
module ladybird_uart
    import ladybird_config::*;
#(
    parameter int XLEN        = 32,
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              anrst,
    input  logic              req,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN/8-1:0] wstrb,
    inout  wire  [XLEN-1:0]   data,
    output logic              gnt,
    output logic              data_gnt,
    input  logic              uart_rx,
`ifdef LADYBIRD_UART_IRQ_EN
    output logic              irq,
`endif
    output logic              uart_tx
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLK_PER_BIT / 2);
    localparam logic [XLEN-1:0] RD_EMPTY = {1'b1, {(XLEN-1){1'b0}}};

    // Bus side
    logic            r_gnt;
    logic            r_rd_pend;
    logic            r_data_gnt;
    logic [XLEN-1:0] r_rdata;
    logic            r_overrun;

    logic            w_sel_data;
    logic            w_sel_stat;
    logic            w_wr;
    logic            w_tx_push_req;
    logic            w_accept;
    logic            w_tx_push;
    logic            w_rx_pop;
    logic            w_stat_rd;
    logic [3:0]      w_stat;
    logic [XLEN-1:0] w_rdata;
    logic            w_unused;

    // FIFO side
    logic [7:0] w_tx_head;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic       w_tx_pop;
    logic [7:0] w_rx_head;
    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_rx_good;

    // TX serializer
    uart_state_t r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_sh;
    logic          r_tx;

    // RX deserializer
    uart_state_t r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_prev;

    assign w_unused = &{1'b0, addr[XLEN-1:4], addr[1:0], data[XLEN-1:8]};

    assign w_sel_data    = (addr[3:2] == UART_DATA_OFFSET[3:2]);
    assign w_sel_stat    = (addr[3:2] == UART_STATUS_OFFSET[3:2]);
    assign w_wr          = |wstrb;
    assign w_tx_push_req = w_sel_data & w_wr & wstrb[0];
    assign w_accept      = req & ~r_gnt & ~(w_tx_push_req & w_tx_full);
    assign w_tx_push     = w_accept & w_tx_push_req;
    assign w_rx_pop      = w_accept & w_sel_data & ~w_wr;
    assign w_stat_rd     = w_accept & w_sel_stat & ~w_wr;

    assign w_tx_pop  = (r_tx_state == START) && (r_tx_cnt == BIT_LAST);
    assign w_rx_good = (r_rx_state == STOP) && (r_rx_cnt == BIT_LAST)
                     && r_rx_s2;

    ladybird_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .anrst   (anrst),
        .i_push  (w_tx_push),
        .i_wdata (data[7:0]),
        .i_pop   (w_tx_pop),
        .o_rdata (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    ladybird_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .anrst   (anrst),
        .i_push  (w_rx_good),
        .i_wdata (r_rx_sh),
        .i_pop   (w_rx_pop),
        .o_rdata (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    // STATUS word assembly.
    always_comb begin
        w_stat = '0;
        w_stat[ST_TX_FULL]     = w_tx_full;
        w_stat[ST_RX_NONEMPTY] = ~w_rx_empty;
        w_stat[ST_TX_BUSY]     = (r_tx_state != IDLE) | ~w_tx_empty;
        w_stat[ST_OVERRUN]     = r_overrun;
    end

    // Read data mux; offsets 0x8/0xC read as zero.
    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_sel_data: w_rdata = w_rx_empty ? RD_EMPTY
                                : {{(XLEN-8){1'b0}}, w_rx_head};
            w_sel_stat: w_rdata = {{(XLEN-4){1'b0}}, w_stat};
            default:    w_rdata = '0;
        endcase
    end

    // Handshake: gnt the cycle after acceptance, data_gnt one after gnt.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_gnt      <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_data_gnt <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_gnt      <= w_accept;
            r_data_gnt <= r_gnt & r_rd_pend;
            if (w_accept) begin
                r_rd_pend <= ~w_wr;
                r_rdata   <= w_rdata;
            end
        end
    end

    assign gnt      = r_gnt;
    assign data_gnt = r_data_gnt;
    assign data     = r_data_gnt ? r_rdata : {XLEN{1'bz}};

    // Sticky overrun; a new overrun beats a same-cycle STATUS clear.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_overrun <= 1'b0;
        end else if (w_rx_good && w_rx_full && !w_rx_pop) begin
            r_overrun <= 1'b1;
        end else if (w_stat_rd) begin
            r_overrun <= 1'b0;
        end
    end

    // TX frame FSM; head byte popped once its start bit completes.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_tx       <= 1'b1;
        end else begin
            unique case (r_tx_state)
                IDLE: begin
                    r_tx     <= 1'b1;
                    r_tx_cnt <= '0;
                    if (!w_tx_empty) begin
                        r_tx_state <= START;
                        r_tx       <= 1'b0;
                        r_tx_sh    <= w_tx_head;
                    end
                end
                START: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= DATA;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_sh[0];
                        r_tx_sh    <= {1'b0, r_tx_sh[7:1]};
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                            r_tx     <= r_tx_sh[0];
                            r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (!w_tx_empty) begin
                            r_tx_state <= START;
                            r_tx       <= 1'b0;
                            r_tx_sh    <= w_tx_head;
                        end else begin
                            r_tx_state <= IDLE;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_state <= IDLE;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

    assign uart_tx = r_tx;

    // Two-flop synchronizer plus edge-detect history for uart_rx.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX frame FSM; start bit rechecked at half a bit to reject glitches.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
        end else begin
            unique case (r_rx_state)
                IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_s2) r_rx_state <= START;
                end
                START: begin
                    if (r_rx_cnt == BIT_HALF) begin
                        r_rx_cnt <= '0;
                        r_rx_bit <= '0;
                        r_rx_state <= r_rx_s2 ? IDLE : DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= STOP;
                        else r_rx_bit <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

`ifdef LADYBIRD_UART_IRQ_EN
    logic r_tx_empty_d;
    logic r_tx_done;
    logic r_irq;

    // TX-drained flag is sticky until STATUS is read; irq is registered.
    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            r_tx_empty_d <= 1'b1;
            r_tx_done    <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_tx_empty_d <= w_tx_empty;
            if (w_tx_empty && !r_tx_empty_d) r_tx_done <= 1'b1;
            else if (w_stat_rd) r_tx_done <= 1'b0;
            r_irq <= ~w_rx_empty | r_overrun | r_tx_done;
        end
    end

    assign irq = r_irq;
`endif

endmodule
